// File: rtl/display_scan_controller_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
//   Shared definitions for the 4-digit multiplexed display scanner:
//   FSM state encoding, message (screen) codes, the all-off anode pattern
//   and small helpers used by the controller and its counters.
// -----------------------------------------------------------------------------
package display_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_GAP  = 2'd1,
        ST_SHOW = 2'd2
    } state_t;

    typedef logic [2:0] msg_t;

    localparam msg_t MSG_S0 = 3'd0;
    localparam msg_t MSG_S1 = 3'd1;
    localparam msg_t MSG_S2 = 3'd2;
    localparam msg_t MSG_S3 = 3'd3;
    localparam msg_t MSG_S4 = 3'd4;

    localparam logic [3:0] ANODO_OFF = 4'b1111;

    // Counter width for a modulo-n counter; a modulus of 1 still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Active-low anode pattern lighting only digit idx.
    function automatic logic [3:0] anodo_digito(input logic [1:0] idx);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << idx);
    endfunction

endpackage

// File: rtl/display_scan_controller_if.sv
// -----------------------------------------------------------------------------
// display_scan_controller_if
//   Message-change handshake between a requester and the scan controller.
//     msg_req    : requester holds high until msg_ack
//     msg_codigo : requested screen code
//     msg_ack    : one-cycle pulse when the request is committed
//     msg_atual  : screen code currently driven to the segment decoders
//   master = requester side, slave = scan controller side.
// -----------------------------------------------------------------------------
interface display_scan_controller_if;
    import display_pkg::*;

    logic msg_req;
    msg_t msg_codigo;
    logic msg_ack;
    msg_t msg_atual;

    modport master (
        output msg_req,
        output msg_codigo,
        input  msg_ack,
        input  msg_atual
    );

    modport slave (
        input  msg_req,
        input  msg_codigo,
        output msg_ack,
        output msg_atual
    );

endinterface

// File: rtl/display_scan_controller_contador_modulo.sv
// -----------------------------------------------------------------------------
// contador_modulo
//   Modulo-N up counter with synchronous clear and enable.
//     clk, rst_n : clock, asynchronous active-low reset
//     i_en       : advance one step (wraps N-1 -> 0)
//     i_clr      : synchronous clear, has priority over i_en
//     o_tc       : terminal count (count == N-1)
// -----------------------------------------------------------------------------
module contador_modulo
    import display_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = cnt_width(N)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tc
);

    logic [W-1:0] r_count;

    assign o_tc = (r_count == W'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_tc ? '0 : r_count + W'(1);
        end
    end

endmodule

// File: rtl/display_scan_controller.sv
// -----------------------------------------------------------------------------
// display_scan_controller
//   Scans a 4-digit common-anode display: each digit is preceded by GAP
//   dead-time cycles (all anodes off) and then lit for PRESCALE cycles.
//   Handles message-change requests (committed only at frame boundaries so a
//   frame never mixes two screens) and optional frame-based blinking.
//   Ports:
//     clock, reset_n   : clock, asynchronous active-low reset
//     habilita         : scan enable; 0 blanks display
//     piscar           : blink enable
//     msg_bus (slave)  : msg_req/msg_codigo in, msg_ack/msg_atual out
//     saida1Contador   : digit index MSB
//     saida2Contador   : digit index LSB
//     anodo            : active-low digit enables
//     quadro_fim       : one-cycle pulse at each 4-digit frame end
// -----------------------------------------------------------------------------
module display_scan_controller
    import display_pkg::*;
#(
    parameter int unsigned PRESCALE     = 50000,
    parameter int unsigned GAP          = 16,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            habilita,
    input  logic                            piscar,
    display_scan_controller_if.slave        msg_bus,
    output logic                            saida1Contador,
    output logic                            saida2Contador,
    output logic [3:0]                      anodo,
    output logic                            quadro_fim
);

    state_t     r_state;
    logic [1:0] r_idx;
    logic [3:0] r_anodo;
    logic       r_quadro_fim;
    msg_t       r_msg_atual;
    logic       r_msg_ack;
    logic       r_pend_valid;
    msg_t       r_pend_code;
    logic       r_fase;

    logic       w_clr;
    logic       w_in_gap;
    logic       w_in_show;
    logic       w_gap_tc;
    logic       w_show_tc;
    logic       w_blink_tc;
    logic       w_frame_end;
    logic       w_commit;
    logic       w_capture;
    logic [3:0] w_anodo_show;

    assign w_clr     = ~habilita;
    assign w_in_gap  = (r_state == ST_GAP);
    assign w_in_show = (r_state == ST_SHOW);

    // Timing counters only run in their own state; each wraps to 0 on the
    // cycle it hands over, so no explicit clear is needed on state change.
    contador_modulo #(.N(GAP)) u_gap_cnt (
        .clk   (clock),
        .rst_n (reset_n),
        .i_en  (w_in_gap),
        .i_clr (w_clr),
        .o_tc  (w_gap_tc)
    );

    contador_modulo #(.N(PRESCALE)) u_show_cnt (
        .clk   (clock),
        .rst_n (reset_n),
        .i_en  (w_in_show),
        .i_clr (w_clr),
        .o_tc  (w_show_tc)
    );

    contador_modulo #(.N(BLINK_FRAMES)) u_blink_cnt (
        .clk   (clock),
        .rst_n (reset_n),
        .i_en  (w_frame_end),
        .i_clr (w_clr),
        .o_tc  (w_blink_tc)
    );

    assign w_frame_end = habilita && w_in_show && w_show_tc && (r_idx == 2'd3);

    // Commit uses the already-registered pending flag, so a request captured
    // on a frame-end edge waits for the next frame end. r_msg_ack blocks
    // re-capture on the edge where the requester is still holding msg_req.
    assign w_commit  = r_pend_valid && (w_frame_end || (r_state == ST_OFF));
    assign w_capture = msg_bus.msg_req && !r_pend_valid && !r_msg_ack;

    assign w_anodo_show = (piscar && r_fase) ? ANODO_OFF : anodo_digito(r_idx);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_OFF;
            r_idx        <= '0;
            r_anodo      <= ANODO_OFF;
            r_quadro_fim <= 1'b0;
            r_msg_atual  <= MSG_S0;
            r_msg_ack    <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_code  <= MSG_S0;
            r_fase       <= 1'b0;
        end else begin
            r_quadro_fim <= w_frame_end;
            r_msg_ack    <= w_commit;

            if (w_commit) begin
                r_msg_atual  <= r_pend_code;
                r_pend_valid <= 1'b0;
            end else if (w_capture) begin
                r_pend_valid <= 1'b1;
                r_pend_code  <= msg_bus.msg_codigo;
            end

            if (!habilita) begin
                r_fase <= 1'b0;
            end else if (w_frame_end && w_blink_tc) begin
                r_fase <= ~r_fase;
            end

            if (!habilita) begin
                r_state <= ST_OFF;
                r_idx   <= '0;
                r_anodo <= ANODO_OFF;
            end else begin
                unique case (r_state)
                    ST_OFF: begin
                        r_state <= ST_GAP;
                        r_anodo <= ANODO_OFF;
                    end
                    ST_GAP: begin
                        if (w_gap_tc) begin
                            r_state <= ST_SHOW;
                            r_anodo <= w_anodo_show;
                        end
                    end
                    ST_SHOW: begin
                        if (w_show_tc) begin
                            r_state <= ST_GAP;
                            r_idx   <= r_idx + 2'd1;
                            r_anodo <= ANODO_OFF;
                        end else begin
                            // Refreshed every cycle so piscar takes effect mid-digit.
                            r_anodo <= w_anodo_show;
                        end
                    end
                    default: begin
                        r_state <= ST_OFF;
                        r_idx   <= '0;
                        r_anodo <= ANODO_OFF;
                    end
                endcase
            end
        end
    end

    assign saida1Contador    = r_idx[1];
    assign saida2Contador    = r_idx[0];
    assign anodo             = r_anodo;
    assign quadro_fim        = r_quadro_fim;
    assign msg_bus.msg_atual = r_msg_atual;
    assign msg_bus.msg_ack   = r_msg_ack;

endmodule

// File: tb/tb_display_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_display_scan_controller
//   Directed bench for display_scan_controller with PRESCALE=4, GAP=2,
//   BLINK_FRAMES=2 (digit slot 6 cycles, frame 24 cycles). Cycle c is the
//   interval after the c-th rising edge counted from scan start; inputs are
//   driven on the falling edge before it and outputs sampled on the next
//   falling edge.
// -----------------------------------------------------------------------------
module tb_display_scan_controller;
    import display_pkg::*;

    localparam int unsigned P         = 4;
    localparam int unsigned G         = 2;
    localparam int unsigned B         = 2;
    localparam int unsigned DIGIT_LEN = G + P;
    localparam int unsigned FRAME_LEN = 4 * DIGIT_LEN;
    localparam int unsigned NVEC      = 30;

    logic       clock    = 1'b0;
    logic       reset_n  = 1'b0;
    logic       habilita = 1'b0;
    logic       piscar   = 1'b0;
    logic       s1;
    logic       s2;
    logic [3:0] anodo;
    logic       quadro_fim;

    display_scan_controller_if bus ();

    display_scan_controller #(
        .PRESCALE     (P),
        .GAP          (G),
        .BLINK_FRAMES (B)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .habilita       (habilita),
        .piscar         (piscar),
        .msg_bus        (bus),
        .saida1Contador (s1),
        .saida2Contador (s2),
        .anodo          (anodo),
        .quadro_fim     (quadro_fim)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       hab;
        logic       req;
        msg_t       cod;
        logic [3:0] e_anodo;
        logic [1:0] e_idx;
        logic       e_qf;
        msg_t       e_atual;
        logic       e_ack;
    } vec_t;

    vec_t vecs [NVEC];

    int unsigned checks   = 0;
    int unsigned failures = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] ea, input logic [1:0] ei,
                             input logic eq, input msg_t em, input logic ek);
        chk({tag, " anodo"},      8'(anodo),         8'(ea));
        chk({tag, " idx"},        8'({s1, s2}),      8'(ei));
        chk({tag, " quadro_fim"}, 8'(quadro_fim),    8'(eq));
        chk({tag, " msg_atual"},  8'(bus.msg_atual), 8'(em));
        chk({tag, " msg_ack"},    8'(bus.msg_ack),   8'(ek));
    endtask

    // Expected anode pattern s cycles into a scan (s=0 is the first GAP cycle).
    function automatic logic [3:0] exp_anodo(input int unsigned s, input logic dark);
        int unsigned pos;
        int unsigned dig;
        logic [3:0]  one;
        pos = s % DIGIT_LEN;
        dig = (s / DIGIT_LEN) % 4;
        one = 4'b0001;
        if (pos < G || dark) return 4'b1111;
        return ~(one << dig);
    endfunction

    function automatic logic [1:0] exp_idx(input int unsigned s);
        return 2'((s / DIGIT_LEN) % 4);
    endfunction

    function automatic logic exp_qf(input int unsigned s);
        return (s > 0) && (s % FRAME_LEN == 0);
    endfunction

    task automatic do_reset();
        reset_n        = 1'b0;
        habilita       = 1'b0;
        piscar         = 1'b0;
        bus.msg_req    = 1'b0;
        bus.msg_codigo = MSG_S0;
        repeat (3) @(negedge clock);
        check_all("reset", 4'b1111, 2'd0, 1'b0, MSG_S0, 1'b0);
        reset_n = 1'b1;
    endtask

    initial begin
        // Scan pattern plus a message request at cycle 5 (code 3), with a
        // code-4 attempt while pending; commit expected at the first frame end.
        for (int unsigned c = 0; c < NVEC; c++) begin
            vecs[c].hab     = 1'b1;
            vecs[c].req     = (c >= 5 && c <= 24);
            vecs[c].cod     = (c >= 8 && c <= 12) ? MSG_S4 : MSG_S3;
            vecs[c].e_anodo = exp_anodo(c, 1'b0);
            vecs[c].e_idx   = exp_idx(c);
            vecs[c].e_qf    = exp_qf(c);
            vecs[c].e_atual = (c >= 24) ? MSG_S3 : MSG_S0;
            vecs[c].e_ack   = (c == 24);
        end

        bus.msg_req    = 1'b0;
        bus.msg_codigo = MSG_S0;

        // Basic scan and frame-end message commit.
        do_reset();
        for (int unsigned c = 0; c < NVEC; c++) begin
            habilita       = vecs[c].hab;
            bus.msg_req    = vecs[c].req;
            bus.msg_codigo = vecs[c].cod;
            @(negedge clock);
            check_all($sformatf("scan c%0d", c), vecs[c].e_anodo, vecs[c].e_idx,
                      vecs[c].e_qf, vecs[c].e_atual, vecs[c].e_ack);
        end

        // Disable mid-SHOW with a pending request: blank next cycle, commit in OFF.
        do_reset();
        for (int unsigned c = 0; c < 21; c++) begin
            logic [3:0] ea;
            logic [1:0] ei;
            msg_t       em;
            habilita       = !(c >= 11 && c <= 13);
            bus.msg_req    = (c >= 7 && c <= 12);
            bus.msg_codigo = MSG_S2;
            @(negedge clock);
            if (c <= 10) begin
                ea = exp_anodo(c, 1'b0);
                ei = exp_idx(c);
            end else if (c <= 13) begin
                ea = 4'b1111;
                ei = 2'd0;
            end else begin
                ea = exp_anodo(c - 14, 1'b0);
                ei = exp_idx(c - 14);
            end
            em = (c >= 12) ? MSG_S2 : MSG_S0;
            check_all($sformatf("hab c%0d", c), ea, ei, 1'b0, em, (c == 12));
        end

        // Blink over 8 frames; a request captured on the first frame-end edge
        // must wait for the second frame end.
        do_reset();
        for (int unsigned c = 0; c < 8 * FRAME_LEN; c++) begin
            logic dark;
            habilita       = 1'b1;
            piscar         = 1'b1;
            bus.msg_req    = (c >= 24 && c <= 48);
            bus.msg_codigo = MSG_S4;
            @(negedge clock);
            dark = ((c / FRAME_LEN) / 2) % 2 == 1;
            check_all($sformatf("blink c%0d", c), exp_anodo(c, dark), exp_idx(c),
                      exp_qf(c), (c >= 48) ? MSG_S4 : MSG_S0, (c == 48));
        end

        // Commit from OFF, then asynchronous reset mid-SHOW on digit 2.
        do_reset();
        for (int unsigned c = 0; c < 17; c++) begin
            habilita       = (c >= 2);
            bus.msg_req    = (c <= 1) || (c >= 10);
            bus.msg_codigo = (c <= 1) ? MSG_S1 : MSG_S3;
            @(negedge clock);
            if (c <= 1) begin
                check_all($sformatf("off c%0d", c), 4'b1111, 2'd0, 1'b0,
                          (c == 1) ? MSG_S1 : MSG_S0, (c == 1));
            end else begin
                check_all($sformatf("pre c%0d", c), exp_anodo(c - 2, 1'b0), exp_idx(c - 2),
                          1'b0, MSG_S1, 1'b0);
            end
        end
        #2 reset_n = 1'b0;
        #1 check_all("async rst", 4'b1111, 2'd0, 1'b0, MSG_S0, 1'b0);
        @(negedge clock);
        bus.msg_req = 1'b0;
        habilita    = 1'b1;
        reset_n     = 1'b1;
        for (int unsigned s = 0; s < 26; s++) begin
            @(negedge clock);
            check_all($sformatf("post s%0d", s), exp_anodo(s, 1'b0), exp_idx(s),
                      exp_qf(s), MSG_S0, 1'b0);
            habilita = 1'b1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
